// File: rtl/vga_vram_addr_seq.sv
// VRAM position-counter sequencer for the VGA text pipeline.
// Turns raster timing into load/increment controls for the 12-bit position counter
// and tracks the glyph row/column used by the font ROM and the pixel shifter.
// The row base advances by one text row every CHAR_H scanlines and wraps modulo
// VRAM_DEPTH so a non-zero scroll base rolls around the end of VRAM.

module vga_vram_addr_seq #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned CHAR_W     = 8,
  parameter int unsigned CHAR_H     = 16,
  parameter int unsigned VRAM_DEPTH = 4096
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_frame_start,
  input  logic                      i_line_start,
  input  logic                      i_de,
  input  logic [11:0]               i_base_addr,
  output logic                      o_ld_h,
  output logic                      o_en_h,
  output logic [11:0]               o_ld_data,
  output logic [$clog2(CHAR_H)-1:0] o_glyph_row,
  output logic [$clog2(CHAR_W)-1:0] o_glyph_col
);

  localparam int unsigned RowW = $clog2(CHAR_H);
  localparam int unsigned ColW = $clog2(CHAR_W);

  // 13-bit constants so the row step and the depth compare never overflow.
  localparam logic [12:0]     Depth13 = 13'(VRAM_DEPTH);
  localparam logic [12:0]     Cols13  = 13'(COLS);
  localparam logic [ColW-1:0] ColLast = ColW'(CHAR_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(CHAR_H - 1);

  // Registered state; every output is taken straight from a flop.
  logic            ld_q, ld_d;
  logic            en_q, en_d;
  logic [11:0]     ld_data_q, ld_data_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic [11:0]     row_base_q, row_base_d;
  logic            de_q;

  // Helper terms.
  logic        line_end;
  logic [12:0] base_sum;
  logic [11:0] base_step;
  logic [11:0] frame_base;

  // Row-step arithmetic and the clamped frame base.
  always_comb begin
    line_end   = de_q & ~i_de;
    base_sum   = {1'b0, row_base_q} + Cols13;
    // Sum stays below 2*VRAM_DEPTH, so one conditional subtraction is enough.
    base_step  = (base_sum >= Depth13) ? 12'(base_sum - Depth13) : 12'(base_sum);
    // An out-of-range scroll base falls back to the top of VRAM.
    frame_base = ({1'b0, i_base_addr} >= Depth13) ? 12'h000 : i_base_addr;
  end

  // Next-state decode; frame start dominates line start and line end.
  always_comb begin
    row_base_d = row_base_q;
    row_d      = row_q;
    col_d      = col_q;
    ld_d       = 1'b0;
    en_d       = 1'b0;
    ld_data_d  = ld_data_q;

    if (i_frame_start) begin
      // A coincident line end is dropped: the frame base replaces any row step.
      row_base_d = frame_base;
      row_d      = '0;
      col_d      = '0;
      ld_d       = 1'b1;
      ld_data_d  = frame_base;
    end else begin
      if (line_end) begin
        if (row_q == RowLast) begin
          row_d      = '0;
          row_base_d = base_step;
        end else begin
          row_d = row_q + RowW'(1);
        end
      end

      if (i_line_start) begin
        // Load the stepped base if a line end lands in the same cycle.
        // A load also suppresses any increment and restarts the cell.
        ld_d      = 1'b1;
        ld_data_d = row_base_d;
        col_d     = '0;
      end else if (i_de) begin
        // Last pixel of a cell advances the counter; col wraps naturally
        // because CHAR_W is a power of two.
        en_d  = (col_q == ColLast);
        col_d = col_q + ColW'(1);
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ld_q       <= 1'b0;
      en_q       <= 1'b0;
      ld_data_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      de_q       <= 1'b0;
    end else begin
      ld_q       <= ld_d;
      en_q       <= en_d;
      ld_data_q  <= ld_data_d;
      row_q      <= row_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      de_q       <= i_de;
    end
  end

  // Output mapping.
  always_comb begin
    o_ld_h      = ld_q;
    o_en_h      = en_q;
    o_ld_data   = ld_data_q;
    o_glyph_row = row_q;
    o_glyph_col = col_q;
  end

endmodule

// File: tb/tb_vga_vram_addr_seq.sv
// Self-checking bench for vga_vram_addr_seq (COLS=80, 8x16 cells, VRAM_DEPTH=2400).
// Stimulus is applied on the falling edge; the expected outputs for that cycle are
// pushed to a scoreboard and popped/compared 1 time unit after the next rising edge.

module tb_vga_vram_addr_seq;

  localparam int unsigned COLS   = 80;
  localparam int unsigned CHAR_W = 8;
  localparam int unsigned CHAR_H = 16;
  localparam int unsigned DEPTH  = 2400;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_frame_start = 1'b0;
  logic        i_line_start = 1'b0;
  logic        i_de = 1'b0;
  logic [11:0] i_base_addr = 12'h000;
  logic        o_ld_h;
  logic        o_en_h;
  logic [11:0] o_ld_data;
  logic [3:0]  o_glyph_row;
  logic [2:0]  o_glyph_col;

  vga_vram_addr_seq #(
    .COLS       (COLS),
    .CHAR_W     (CHAR_W),
    .CHAR_H     (CHAR_H),
    .VRAM_DEPTH (DEPTH)
  ) u_dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_frame_start (i_frame_start),
    .i_line_start  (i_line_start),
    .i_de          (i_de),
    .i_base_addr   (i_base_addr),
    .o_ld_h        (o_ld_h),
    .o_en_h        (o_en_h),
    .o_ld_data     (o_ld_data),
    .o_glyph_row   (o_glyph_row),
    .o_glyph_col   (o_glyph_col)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        ld;
    logic        en;
    int unsigned data;
    int unsigned row;
    int unsigned col;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned en_seen  = 0;
  int unsigned last_ld  = 0;

  // Reference state, written from the behavioural description.
  int unsigned m_base    = 0;
  int unsigned m_row     = 0;
  int unsigned m_col     = 0;
  int unsigned m_ld_data = 0;
  bit          m_de_d    = 1'b0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Scoreboard consumer.
  always @(posedge i_clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check_eq("ld_h", o_ld_h, mon_e.ld);
      check_eq("en_h", o_en_h, mon_e.en);
      check_eq("ld_data", o_ld_data, mon_e.data);
      check_eq("glyph_row", o_glyph_row, mon_e.row);
      check_eq("glyph_col", o_glyph_col, mon_e.col);
      if (o_ld_h) last_ld = o_ld_data;
      if (o_en_h) en_seen++;
    end
  end

  // Drive one cycle of inputs and predict the outputs that follow it.
  task automatic apply(input logic fs, input logic ls, input logic de);
    exp_t e;
    i_frame_start = fs;
    i_line_start  = ls;
    i_de          = de;
    e.ld = 1'b0;
    e.en = 1'b0;
    if (fs) begin
      m_base    = (i_base_addr >= DEPTH) ? 0 : i_base_addr;
      m_row     = 0;
      m_col     = 0;
      m_ld_data = m_base;
      e.ld      = 1'b1;
    end else begin
      if (m_de_d && !de) begin
        if (m_row == CHAR_H - 1) begin
          m_row  = 0;
          m_base = (m_base + COLS) % DEPTH;
        end else begin
          m_row = m_row + 1;
        end
      end
      if (ls) begin
        e.ld      = 1'b1;
        m_ld_data = m_base;
        m_col     = 0;
      end else if (de) begin
        e.en  = (m_col == CHAR_W - 1);
        m_col = (m_col + 1) % CHAR_W;
      end
    end
    m_de_d = de;
    e.data = m_ld_data;
    e.row  = m_row;
    e.col  = m_col;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic fs, input logic ls, input logic de);
    @(negedge i_clk);
    apply(fs, ls, de);
  endtask

  // Let the last pushed expectation be consumed.
  task automatic drain();
    @(posedge i_clk);
    #2;
  endtask

  task automatic frame(input logic [11:0] base, input int unsigned exp_ld);
    @(negedge i_clk);
    i_base_addr = base;
    apply(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    drain();
    check_eq("frame_ld", last_ld, exp_ld);
  endtask

  // Line start, two idle cycles, n_px active pixels, three blank cycles.
  task automatic run_line(input int unsigned n_px);
    en_seen = 0;
    step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    for (int p = 0; p < n_px; p++) step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    drain();
    check_eq("en_count", en_seen, n_px / CHAR_W);
  endtask

  // Asynchronous reset between clock edges, then continue the active run.
  task automatic reset_mid();
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check_eq("rst_ld_h", o_ld_h, 0);
    check_eq("rst_en_h", o_en_h, 0);
    check_eq("rst_ld_data", o_ld_data, 0);
    check_eq("rst_glyph_row", o_glyph_row, 0);
    check_eq("rst_glyph_col", o_glyph_col, 0);
    m_base = 0; m_row = 0; m_col = 0; m_ld_data = 0; m_de_d = 1'b0;
    #1;
    i_rst = 1'b0;
    apply(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #1 i_rst = 1'b1;
    #2;
    check_eq("reset_ld_h", o_ld_h, 0);
    check_eq("reset_en_h", o_en_h, 0);
    check_eq("reset_ld_data", o_ld_data, 0);
    check_eq("reset_glyph_row", o_glyph_row, 0);
    check_eq("reset_glyph_col", o_glyph_col, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Frame from base 0, one full 640-pixel line, then 16 more lines.
    frame(12'h000, 0);
    run_line(640);
    for (int l = 1; l <= 16; l++) begin
      if (l == 5) i_base_addr = 12'h777;
      run_line((l == 16) ? 100 : 64);
      if (l == 15) check_eq("line15_ld", last_ld, 12'h000);
      if (l == 16) check_eq("line16_ld", last_ld, 12'h050);
    end
    // Blanked line: no row step.
    run_line(0);

    // Coincident frame and line start: one load with the frame base.
    @(negedge i_clk);
    i_base_addr = 12'h123;
    apply(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    drain();
    check_eq("coinc_ld", last_ld, 12'h123);
    run_line(64);
    check_eq("coinc_line_ld", last_ld, 12'h123);

    // Reset in the middle of an active run.
    en_seen = 0;
    step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    repeat (13) step(1'b0, 1'b0, 1'b1);
    reset_mid();
    repeat (19) step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    drain();
    check_eq("rst_en_count", en_seen, 3);

    // Wrap around VRAM_DEPTH from base 2320.
    frame(12'd2320, 2320);
    for (int l = 0; l <= 32; l++) begin
      run_line(16);
      if (l == 16) check_eq("wrap_l16", last_ld, 0);
      if (l == 32) check_eq("wrap_l32", last_ld, 80);
    end

    // Out-of-range base clamps to 0.
    frame(12'hFFF, 0);
    run_line(24);
    check_eq("clamp_line_ld", last_ld, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
